// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low keypad matrix, debounces presses and releases, and
// decodes the accepted key into calculator events.
//
// Key layout (row r, column c):
//   r0: 1 2 3 A    r1: 4 5 6 B    r2: 7 8 9 C    r3: * 0 # D
//   A..D -> operator 0..3 (add, sub, mul, div), '*' -> erase, '#' -> equal.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-low reset
//   row[3:0]    out  row drive, active-low one-hot
//   col[3:0]    in   column sense, active-low, asynchronous, pulled up
//   num[3:0]    out  last accepted digit, held until the next digit
//   numPressed  out  one-clock pulse coincident with a num update
//   op[1:0]     out  last accepted operator, held until the next operator
//   opPressed   out  one-clock pulse coincident with an op update
//   erase       out  one-clock pulse when '*' is accepted
//   equal       out  one-clock pulse when '#' is accepted
//
// Build option
//   KEYPAD_REPEAT_EN  when defined, a held digit key re-issues its pulse
//                     every REPEAT_CYCLES clocks while it stays down.
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] num,
  output logic       numPressed,
  output logic [1:0] op,
  output logic       opPressed,
  output logic       erase,
  output logic       equal
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_DIV) ? DEBOUNCE_CYCLES : SCAN_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESS,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [1:0]    r_row_idx, w_row_idx_next;
  logic [1:0]    r_key_col, w_key_col_next;
  logic [3:0]    r_col_meta, r_col_sync;
  logic          w_one_low;
  logic [1:0]    w_low_idx;
  logic          w_col_match;
  logic          w_col_idle;
  logic          w_is_digit, w_is_op, w_is_erase, w_is_equal;
  logic [3:0]    w_digit;
  logic          w_rep_tick;
  logic          w_fire;
  logic [3:0]    r_num;
  logic [1:0]    r_op;
  logic          r_num_p, r_op_p, r_erase, r_equal;

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_col_meta <= 4'b1111;
      r_col_sync <= 4'b1111;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
    end
  end

  // Exactly one low column is a valid key; zero or several low bits are
  // treated as "no key" so simultaneous presses are ignored.
  always_comb begin
    w_one_low = 1'b0;
    w_low_idx = 2'd0;
    case (r_col_sync)
      4'b1110: begin w_one_low = 1'b1; w_low_idx = 2'd0; end
      4'b1101: begin w_one_low = 1'b1; w_low_idx = 2'd1; end
      4'b1011: begin w_one_low = 1'b1; w_low_idx = 2'd2; end
      4'b0111: begin w_one_low = 1'b1; w_low_idx = 2'd3; end
      default: begin w_one_low = 1'b0; w_low_idx = 2'd0; end
    endcase
  end

  assign w_col_match = (r_col_sync == ~(4'b0001 << r_key_col));
  assign w_col_idle  = (r_col_sync == 4'b1111);
  // The shared counter saturates instead of wrapping.
  assign w_cnt_inc   = (r_cnt == CW'(CNT_MAX)) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_SCAN;
      r_cnt     <= '0;
      r_row_idx <= 2'd0;
      r_key_col <= 2'd0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_row_idx <= w_row_idx_next;
      r_key_col <= w_key_col_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_row_idx_next = r_row_idx;
    w_key_col_next = r_key_col;
    case (r_state)
      S_SCAN: begin
        if (r_cnt == CW'(SCAN_DIV - 1)) begin
          w_cnt_next = '0;
          if (w_one_low) begin
            w_state_next   = S_DEBOUNCE;
            w_key_col_next = w_low_idx;
          end else begin
            w_row_idx_next = r_row_idx + 2'd1;
          end
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_DEBOUNCE: begin
        if (!w_col_match) begin
          w_state_next = S_SCAN;
          w_cnt_next   = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state_next = S_PRESS;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_PRESS: begin
        w_state_next = S_HOLD;
        w_cnt_next   = '0;
      end
      S_HOLD: begin
        if (w_col_idle) begin
          w_state_next = S_RELEASE;
          w_cnt_next   = '0;
        end
      end
      S_RELEASE: begin
        if (!w_col_idle) begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          // Resume on the next row so a just-released key is not re-found first.
          w_state_next   = S_SCAN;
          w_cnt_next     = '0;
          w_row_idx_next = r_row_idx + 2'd1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = S_SCAN;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Key decode from the frozen row and latched column. Column 3 holds the
  // operators, so the operator code is simply the row index.
  always_comb begin
    w_is_digit = 1'b0;
    w_is_op    = 1'b0;
    w_is_erase = 1'b0;
    w_is_equal = 1'b0;
    w_digit    = 4'd0;
    if (r_key_col == 2'd3) begin
      w_is_op = 1'b1;
    end else if (r_row_idx != 2'd3) begin
      w_is_digit = 1'b1;
      w_digit    = {2'b00, r_row_idx} * 4'd3 + {2'b00, r_key_col} + 4'd1;
    end else begin
      case (r_key_col)
        2'd0:    w_is_erase = 1'b1;
        2'd1:    w_is_digit = 1'b1;
        default: w_is_equal = 1'b1;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] r_rep_cnt;

  assign w_rep_tick = (r_state == S_HOLD) && w_is_digit && !w_col_idle &&
                      (r_rep_cnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rep_cnt <= '0;
    end else if ((r_state != S_HOLD) || w_rep_tick) begin
      r_rep_cnt <= '0;
    end else if (r_rep_cnt != RW'(REPEAT_CYCLES)) begin
      r_rep_cnt <= r_rep_cnt + RW'(1);
    end
  end
`else
  // No auto-repeat: REPEAT_CYCLES is always positive, so this is constant 0.
  assign w_rep_tick = (REPEAT_CYCLES < 0);
`endif

  assign w_fire = (r_state == S_PRESS) || w_rep_tick;

  // Registered outputs: each pulse and its value update land on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_num   <= 4'd0;
      r_op    <= 2'd0;
      r_num_p <= 1'b0;
      r_op_p  <= 1'b0;
      r_erase <= 1'b0;
      r_equal <= 1'b0;
    end else begin
      r_num_p <= w_fire && w_is_digit;
      r_op_p  <= w_fire && w_is_op;
      r_erase <= w_fire && w_is_erase;
      r_equal <= w_fire && w_is_equal;
      if (w_fire && w_is_digit) r_num <= w_digit;
      if (w_fire && w_is_op)    r_op  <= r_row_idx;
    end
  end

  assign row        = ~(4'b0001 << r_row_idx);
  assign num        = r_num;
  assign op         = r_op;
  assign numPressed = r_num_p;
  assign opPressed  = r_op_p;
  assign erase      = r_erase;
  assign equal      = r_equal;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Drives a behavioural 4x4 keypad (a set of pressed keys that pulls columns
// low for whichever row the scanner drives) and checks the decoded events
// through a scoreboard queue. Expected events come from the printed key
// layout string, not from the design.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row, col, num;
  logic [1:0] op;
  logic       numPressed, opPressed, erase, equal;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .num(num),
    .numPressed(numPressed),
    .op(op),
    .opPressed(opPressed),
    .erase(erase),
    .equal(equal)
  );

  // Physical keypad: key index = r*4 + c.
  logic [15:0] key_dn;
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && key_dn[r*4+c]) col[c] = 1'b0;
  end

  typedef struct {
    int kind;   // 0 digit, 1 operator, 2 erase, 3 equal
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  pulse_seen = 0;
  int  cyc = 0;
  int  last_pulse_cyc = 0;
  int  model_num = 0;
  int  model_op  = 0;

  function automatic ev_t key_event(input int idx);
    string km;
    byte   ch;
    ev_t   e;
    km = "123A456B789C*0#D";
    ch = km[idx];
    e.kind = 0;
    e.val  = 0;
    if (ch >= 8'd48 && ch <= 8'd57) begin
      e.kind = 0; e.val = int'(ch) - 48;
    end else if (ch >= 8'd65 && ch <= 8'd68) begin
      e.kind = 1; e.val = int'(ch) - 65;
    end else if (ch == 8'd42) begin
      e.kind = 2;
    end else begin
      e.kind = 3;
    end
    return e;
  endfunction

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        cyc = 0;
        model_num = 0;
        model_op  = 0;
      end else begin
        cyc++;
        if (numPressed || opPressed || erase || equal) begin
          ev_t got;
          ev_t want;
          int  nhot;
          pulse_seen++;
          last_pulse_cyc = cyc;
          nhot = int'(numPressed) + int'(opPressed) + int'(erase) + int'(equal);
          got.kind = numPressed ? 0 : opPressed ? 1 : erase ? 2 : 3;
          got.val  = numPressed ? int'(num) : opPressed ? int'(op) : 0;
          total++;
          if (nhot != 1) begin
            bad++;
            $display("FAIL onehot cyc=%0d pulses=%0d required 1", cyc, nhot);
          end
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse cyc=%0d got kind=%0d val=%0d required no pulse",
                     cyc, got.kind, got.val);
          end else begin
            want = exp_q.pop_front();
            if (got.kind != want.kind || got.val != want.val) begin
              bad++;
              $display("FAIL event cyc=%0d got kind=%0d val=%0d required kind=%0d val=%0d",
                       cyc, got.kind, got.val, want.kind, want.val);
            end else begin
              $display("event cyc=%0d kind=%0d val=%0d ok", cyc, got.kind, got.val);
            end
            if (want.kind == 0) model_num = want.val;
            if (want.kind == 1) model_op  = want.val;
          end
        end
        total++;
        if (num != 4'(model_num) || op != 2'(model_op)) begin
          bad++;
          $display("FAIL held_value cyc=%0d got num=%0d op=%0d required num=%0d op=%0d",
                   cyc, num, op, model_num, model_op);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input string name, input int budget);
    int start;
    int n;
    start = pulse_seen;
    n = 0;
    while (pulse_seen == start && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    total++;
    if (pulse_seen == start) begin
      bad++;
      $display("FAIL %s no pulse within %0d clocks, required one", name, budget);
    end
  endtask

  task automatic check_reset(input string name);
    total++;
    if (row != 4'b1110) begin
      bad++; $display("FAIL %s row got=%b required 1110", name, row);
    end
    total++;
    if (num != 4'd0) begin
      bad++; $display("FAIL %s num got=%0d required 0", name, num);
    end
    total++;
    if (op != 2'd0) begin
      bad++; $display("FAIL %s op got=%0d required 0", name, op);
    end
    total++;
    if ({numPressed, opPressed, erase, equal} != 4'b0000) begin
      bad++; $display("FAIL %s pulses got=%b required 0000", name,
                      {numPressed, opPressed, erase, equal});
    end
  endtask

  // Press one key, expect its event, hold briefly, release and let it settle.
  task automatic press_key(input int idx);
    exp_q.push_back(key_event(idx));
    @(negedge clk);
    key_dn = 16'(1) << idx;
    wait_pulse($sformatf("key%0d", idx), 60);
    tick(10);
    key_dn = '0;
    tick(20);
  endtask

  initial begin
    int         n;
    logic [3:0] exp_row;

    reset  = 1'b0;
    key_dn = '0;
    tick(3);
    check_reset("reset_state");
    reset = 1'b1;

    // Idle scan: each row is driven for SCAN_DIV clocks.
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      exp_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      total++;
      if (row != exp_row) begin
        bad++;
        $display("FAIL scan_rotation k=%0d got=%b required %b", k, row, exp_row);
      end
    end

    // Key '5' held from reset release: found at the end of row 1's dwell,
    // then DEB debounce clocks plus the PRESS clock.
    @(negedge clk);
    reset = 1'b0;
    tick(3);
    reset  = 1'b1;
    key_dn = 16'(1) << 5;
    exp_q.push_back(key_event(5));
    wait_pulse("key5", 40);
    total++;
    if (last_pulse_cyc != 2 * SCAN_DIV + DEB + 1) begin
      bad++;
      $display("FAIL latency5 got=%0d required %0d", last_pulse_cyc, 2 * SCAN_DIV + DEB + 1);
    end
    while (cyc < 40) @(negedge clk);
    key_dn = '0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (row == 4'b1101 && n < 30);
    // 2 synchronizer clocks, 1 clock to leave HOLD, DEB release clocks.
    total++;
    if (n != DEB + 3) begin
      bad++; $display("FAIL release_time got=%0d required %0d", n, DEB + 3);
    end
    total++;
    if (row != 4'b1011) begin
      bad++; $display("FAIL resume_row got=%b required 1011", row);
    end
    tick(5);

    // Key 'B' bouncing every 3 clocks: nothing may be accepted.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_dn[7] = ~key_dn[7];
      tick(2);
    end
    key_dn = '0;
    press_key(7);

    // '1' and '2' together are ignored; releasing '2' accepts '1'.
    @(negedge clk);
    key_dn = 16'b0000_0000_0000_0011;
    tick(40);
    exp_q.push_back(key_event(0));
    key_dn[1] = 1'b0;
    wait_pulse("multikey", 60);
    tick(10);
    key_dn = '0;
    tick(20);

    // '*', '#', '0' in order.
    press_key(12);
    press_key(14);
    press_key(13);

    // Random single keys.
    for (int i = 0; i < 12; i++) press_key(int'($urandom_range(0, 15)));

    // Reset during debounce of '7': no pulse, then a full re-acceptance.
    @(negedge clk);
    key_dn = 16'(1) << 8;
    tick(6);
    reset = 1'b0;
    tick(3);
    check_reset("reset_midpress");
    exp_q.push_back(key_event(8));
    reset = 1'b1;
    wait_pulse("after_reset7", 60);
    tick(10);
    key_dn = '0;
    tick(20);

`ifdef KEYPAD_REPEAT_EN
    // '9' held about 58 clocks after acceptance: pulses at +0, +16, +32, +48.
    for (int i = 0; i < 4; i++) exp_q.push_back(key_event(10));
    @(negedge clk);
    key_dn = 16'(1) << 10;
    wait_pulse("repeat9", 60);
    tick(58);
    key_dn = '0;
    tick(20);
    // Reset while repeating: pulses at +0 and +16 only.
    for (int i = 0; i < 2; i++) exp_q.push_back(key_event(10));
    @(negedge clk);
    key_dn = 16'(1) << 10;
    wait_pulse("repeat9_reset", 60);
    tick(20);
    reset  = 1'b0;
    key_dn = '0;
    tick(3);
    reset = 1'b1;
    tick(40);
`endif

    tick(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, 1000, clocks each row is driven before its columns are sampled (>=4).
REQ-002 Parameter DEBOUNCE_CYCLES, 20000, consecutive stable clocks needed to accept a press or a release (>=2).
REQ-003 Parameter REPEAT_CYCLES, 500000, hold time per auto-repeat pulse (used only with KEYPAD_REPEAT_EN).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 row  output  4  matrix row drive, active-low one-hot.
REQ-007 col  input  4  matrix column sense, active-low, asynchronous to clk, externally pulled up.
REQ-008 num  output  4  last accepted digit 0-9; held until the next digit.
REQ-009 numPressed  output  1  one-clock pulse, coincident with num update.
REQ-010 op  output  2  last accepted operator: 0 add, 1 sub, 2 mul, 3 div.
REQ-011 opPressed  output  1  one-clock pulse, coincident with op update.
REQ-012 erase  output  1  one-clock pulse when '*' is accepted.
REQ-013 equal  output  1  one-clock pulse when '#' is accepted.

Function
REQ-014 Key map (row r, col c, both 0-3): r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D"; A-D map to op 0-3.
REQ-015 col passes through a two-flop synchronizer, reset value 4'b1111; all decisions use the synchronized value (colS).
REQ-016 States: SCAN, DEBOUNCE, PRESS, HOLD, RELEASE.
REQ-017 SCAN: row counter runs 0..SCAN_DIV-1; at count SCAN_DIV-1, if colS has exactly one low bit, latch row/col and go DEBOUNCE; otherwise advance row 0->1->2->3->0 and clear the counter.
REQ-018 colS with two or more low bits counts as no key (multi-key press ignored).
REQ-019 DEBOUNCE: row frozen; counter increments while colS equals the latched column; any mismatch returns to SCAN on the same row with the counter cleared; reaching DEBOUNCE_CYCLES goes to PRESS.
REQ-020 PRESS: lasts exactly one clock; asserts the single pulse output for the decoded key and updates num or op in the same cycle; then goes HOLD.
REQ-021 HOLD: row frozen; no further pulses; colS == 4'b1111 goes RELEASE.
REQ-022 RELEASE: counter increments while colS == 4'b1111; any low bit returns to HOLD; reaching DEBOUNCE_CYCLES goes SCAN starting at the row after the released row.
REQ-023 Press-to-pulse latency: DEBOUNCE_CYCLES+1 clocks after the DEBOUNCE entry, plus 2 synchronizer clocks.
REQ-024 At most one of numPressed/opPressed/erase/equal is high in any cycle.
REQ-025 Counters saturate; no wrap-around is permitted in any state.

Reset
REQ-026 While reset is 0 at a clock edge: state SCAN, row 4'b1110, counters 0, synchronizer 4'b1111, num 0, op 0, all pulses 0.
REQ-027 Reset asserted mid-press aborts without a pulse; a key still held after reset is accepted only through a full SCAN/DEBOUNCE cycle.

Configuration
REQ-028 Macro KEYPAD_REPEAT_EN defined: in HOLD, for digit keys only, a counter repeats the PRESS pulse with the same value every REPEAT_CYCLES while the key stays down; the counter clears on leaving HOLD.
REQ-029 Macro KEYPAD_REPEAT_EN undefined: no repeat logic; exactly one pulse per press.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=16)
REQ-030 Reset low for 3 clocks -> row=1110, num=0, op=0, all pulses 0; after release row rotates 1110->1101->1011->0111 every 4 clocks.
REQ-031 Hold key '5' (col=1101 while row=1101) for 40 clocks -> single numPressed pulse with num=5, then no pulse until release; after 8 high clocks, scanning resumes at row 1011.
REQ-032 Key 'B' bouncing (col toggles every 3 clocks, then stable) -> no pulse during bounce; one opPressed pulse with op=1 after 8 stable clocks.
REQ-033 Keys '1' and '2' pressed together (col=1100 on row 0) -> no pulse; release '2' -> numPressed pulse with num=1.
REQ-034 '*', then '#', then '0' -> erase, equal, numPressed (num=0) pulses in order, each exactly one clock, never overlapping.
REQ-035 With KEYPAD_REPEAT_EN, hold '9' for 60 clocks after acceptance -> pulses with num=9 at acceptance, then every 16 clocks (4 total); reset low mid-hold -> no further pulses.
